// File: rtl/manchester_bit_decoder_if.sv
// Bus between a DECtape Manchester read channel and its bit decoder.
// The master side drives the raw read level and the enable; the slave side
// (the decoder) returns lock status, recovered bits and mark detection.
interface manchester_bit_decoder_if;
    logic       rd_n;
    logic       enable;
    logic       locked;
    logic       bit_valid;
    logic       bit_data;
    logic       err;
    logic [5:0] shift;
    logic       mark_hit;

    modport master (
        output rd_n,
        output enable,
        input  locked,
        input  bit_valid,
        input  bit_data,
        input  err,
        input  shift,
        input  mark_hit
    );

    modport slave (
        input  rd_n,
        input  enable,
        output locked,
        output bit_valid,
        output bit_data,
        output err,
        output shift,
        output mark_hit
    );
endinterface

// File: rtl/manchester_bit_decoder.sv
// Manchester bit decoder for one DECtape read track.
// Synchronizes and glitch-filters the active-low read level, hunts for a run
// of full-cell edge spacings to lock onto mid-bit transitions, then emits one
// bit per cell and tracks a 6-bit window against a programmable mark code.
module manchester_bit_decoder #(
    parameter int         BIT_CYC   = 3200,
    parameter int         FILT      = 8,
    parameter int         PRE_EDGES = 4,
    parameter logic [5:0] MARK      = 6'o25
) (
    input logic                     clk,
    input logic                     reset,
    manchester_bit_decoder_if.slave bus
);

    // Acceptance window for a mid-bit edge and the dropout limit, in cycles.
    localparam logic [15:0] LO        = 16'(BIT_CYC * 3 / 4);
    localparam logic [15:0] HI        = 16'(BIT_CYC * 5 / 4);
    localparam logic [15:0] TO        = 16'(BIT_CYC * 3 / 2);
    localparam logic [15:0] TMR_MAX   = 16'hFFFF;
    localparam logic [7:0]  FILT_LAST = 8'(FILT - 1);
    localparam logic [3:0]  LOCK_CNT  = 4'(PRE_EDGES);

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic        sync1;
    logic        sync2;
    logic        lvl;
    logic        lvl_prev;
    logic [7:0]  fcnt;

    logic        edge_seen;
    logic        head_rise;
    logic        in_win;
    logic        timeout;

    logic [0:0]  state;
    logic [0:0]  state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [3:0]  cnt_inc;
    logic [15:0] tmr;
    logic [15:0] tmr_nxt;
    logic        emit;
    logic        lose;

    logic        locked_q;
    logic        bit_valid_q;
    logic        bit_data_q;
    logic        err_q;
    logic [5:0]  shift_q;
    logic [5:0]  shift_nxt;
    logic        mark_hit_q;

    // Two-flop synchronizer; idle read level (rd_n high) is the reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= bus.rd_n;
            sync2 <= sync1;
        end
    end

    // Glitch filter: lvl follows the synchronized level only after it has disagreed for FILT straight cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl  <= 1'b1;
            fcnt <= '0;
        end else if (sync2 != lvl) begin
            if (fcnt == FILT_LAST) begin
                lvl  <= sync2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 8'd1;
            end
        end else begin
            fcnt <= '0;
        end
    end

    // Previous filtered level, used to spot the cycle on which lvl changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_prev <= 1'b1;
        end else begin
            lvl_prev <= lvl;
        end
    end

    // A falling rd_n is a rising head level, which decodes as a 1.
    assign edge_seen = (lvl != lvl_prev);
    assign head_rise = lvl_prev & ~lvl;
    assign in_win    = (tmr >= LO) && (tmr <= HI);
    assign timeout   = (tmr >= TO);
    assign cnt_inc   = cnt + 4'd1;
    assign shift_nxt = {shift_q[4:0], head_rise};

    // Hunt/lock decisions for the current cycle; a late edge and a timeout both lose lock.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tmr_nxt   = (tmr == TMR_MAX) ? tmr : tmr + 16'd1;
        emit      = 1'b0;
        lose      = 1'b0;
        if (!bus.enable) begin
            state_nxt = HUNT;
            cnt_nxt   = '0;
            tmr_nxt   = '0;
        end else begin
            case (state)
                HUNT: begin
                    if (edge_seen) begin
                        tmr_nxt = '0;
                        if (in_win) begin
                            cnt_nxt = cnt_inc;
                            if (cnt_inc == LOCK_CNT) begin
                                state_nxt = LOCK;
                            end
                        end else begin
                            cnt_nxt = '0;
                        end
                    end
                end
                default: begin
                    if (timeout || (edge_seen && (tmr > HI))) begin
                        lose      = 1'b1;
                        state_nxt = HUNT;
                        cnt_nxt   = '0;
                        tmr_nxt   = '0;
                    end else if (edge_seen && (tmr >= LO)) begin
                        emit    = 1'b1;
                        tmr_nxt = '0;
                    end
                end
            endcase
        end
    end

    // Hunt/lock state, preamble edge count and the cell timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HUNT;
            cnt   <= '0;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tmr   <= tmr_nxt;
        end
    end

    // Registered outputs; bit_data and shift hold between recovered bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked_q    <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_data_q  <= 1'b0;
            err_q       <= 1'b0;
            shift_q     <= '0;
            mark_hit_q  <= 1'b0;
        end else begin
            locked_q    <= (state_nxt == LOCK);
            bit_valid_q <= emit;
            err_q       <= lose;
            mark_hit_q  <= emit && (shift_nxt == MARK);
            if (emit) begin
                bit_data_q <= head_rise;
                shift_q    <= shift_nxt;
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.bit_data  = bit_data_q;
    assign bus.err       = err_q;
    assign bus.shift     = shift_q;
    assign bus.mark_hit  = mark_hit_q;

endmodule

// File: doc/manchester_bit_decoder.md
# manchester_bit_decoder

Recovers serial data bits from one DECtape-style Manchester read channel. Sits directly downstream of the Manchester reader/writer card: it takes that card's active-low read output for one track, synchronizes and filters it, locks to the mid-bit transitions and emits one bit per bit cell. It also keeps a 6-bit window of recent bits and pulses when the window matches a programmable mark code.

## Interface
- BIT_CYC, 3200: nominal bit cell length in clk cycles (32 µs at 100 MHz); 16 ≤ BIT_CYC ≤ 40000
- FILT, 8: glitch filter length in cycles; 1..255
- PRE_EDGES, 4: consecutive full-cell edge intervals required to lock; 1..15
- MARK, 6'o25: 6-bit pattern compared against the bit window

- clk  in  1  100 MHz system clock; all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state
- rd_n  in  1  asynchronous read level from the reader card; head level = !rd_n
- enable  in  1  synchronous; low forces HUNT and suppresses all outputs
- locked  out  1  high while in LOCK
- bit_valid  out  1  one-cycle pulse per recovered bit
- bit_data  out  1  recovered bit; valid when bit_valid is high, holds otherwise
- err  out  1  one-cycle pulse on loss of lock
- shift  out  6  last six recovered bits, newest in bit 0
- mark_hit  out  1  one-cycle pulse, coincident with bit_valid, when the updated shift equals MARK

## Operation
- Input path: two-flop synchronizer on rd_n, then filter. The filtered level `lvl` takes the synchronized value only after it has differed from `lvl` for FILT consecutive cycles. Synchronizer flops and `lvl` reset to 1.
- Edge: `lvl` changes. Direction is rising when the head level rises, i.e. rd_n falls.
- `tmr`: 16-bit counter of cycles since the reference edge. Increments every cycle, saturates at 0xFFFF and resets to 0.
- Windows: LO = BIT_CYC*3/4, HI = BIT_CYC*5/4, TO = BIT_CYC*3/2. All are integer-truncated constants.
- State HUNT (reset state):
  - Every edge sets `tmr` to 0.
  - If `tmr` at the edge is in [LO, HI], `cnt` increments; otherwise `cnt` is set to 0.
  - When `cnt` reaches PRE_EDGES, go to LOCK and treat that edge as mid-bit. No bit is emitted for it.
  - The transmitter preamble is alternating bits, so its edges fall only at mid-bit.
- State LOCK:
  - Edge with `tmr` < LO: cell-boundary edge; ignored, `tmr` keeps counting.
  - Edge with LO ≤ `tmr` ≤ HI: mid-bit edge. Emit bit_valid with bit_data = 1 for a rising edge and 0 for a falling edge. Shift left with the new bit into bit 0. Set `tmr` to 0.
  - Edge with `tmr` > HI, or `tmr` reaching TO with no edge: pulse err, go to HUNT, set `cnt` to 0 and `tmr` to 0.
- An edge and the timeout on the same cycle count as an edge arriving after HI: the result is err.
- enable low: state goes to HUNT, `cnt` and `tmr` are 0, and no bit_valid, err or mark_hit pulses occur. `shift` holds. The filter keeps running.
- `shift` is not cleared on loss of lock. It is cleared only by reset.
- Reset values: locked 0, bit_valid 0, bit_data 0, err 0, shift 0, mark_hit 0, state HUNT, `cnt` 0, `tmr` 0.

## Timing
- A rd_n change reaches `lvl` FILT+2 cycles after it is first sampled.
- The edge is evaluated on the cycle `lvl` changes. bit_valid, bit_data, shift, mark_hit, err and locked are registered and update one cycle later.
- Total latency from the rd_n transition to bit_valid: FILT+3 cycles (11 with defaults), ±1 cycle of synchronizer uncertainty.
- Every output pulse is exactly one cycle wide. There is no back-pressure; a consumer must accept every bit_valid.
- Reset asserted mid-cell immediately clears all state and outputs. After reset deasserts, at least PRE_EDGES+1 preamble edges are needed before locked rises.

## Test plan
- Lock: alternating preamble 0,1,0,1… with BIT_CYC=3200, FILT=8, PRE_EDGES=4 -> locked rises 1 cycle after the 5th mid-bit edge has passed the filter; no bit_valid before that point.
- Data: after lock, send bits 1,1,0,0,1,0 (boundary edges at half-cells) -> six bit_valid pulses 3200±1 cycles apart with data 1,1,0,0,1,0; shift = 6'b110010; boundary edges produce no pulse.
- Mark: after lock, send 0,1,0,1,0,1 with MARK=6'o25 -> mark_hit coincides with the 6th bit_valid; no other mark_hit.
- Glitch and jitter: 5-cycle rd_n pulses inserted mid-cell -> no effect; mid-bit edges shifted ±700 cycles -> bits still decoded correctly.
- Dropout: after lock, hold rd_n constant -> err pulses at `tmr` = 4800, locked falls, no further bit_valid; resuming the preamble relocks.
- Control: enable low for 100 cycles while locked -> locked 0, no pulses, shift unchanged. Reset asserted mid-cell -> all outputs 0 within the same cycle.
